// File: rtl/ifu_pc_gen_pkg.sv
// Shared constants and BTB counter helpers for the fetch-address generator.
// Build with IFU_BTB_EN defined to include the branch target buffer.
package ifu_pc_gen_pkg;

  localparam int InstAddrBus = 32;

  localparam logic RstEnable    = 1'b1;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic Branch       = 1'b1;
  localparam logic NotBranch    = 1'b0;
  localparam logic BranchNotEnd = 1'b0;

  localparam logic [InstAddrBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Saturating step of a 2-bit counter toward the resolved direction
  function automatic ctr_e ctr_step(ctr_e c, logic taken);
    ctr_e r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = ctr_e'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) r = ctr_e'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ifu_pc_gen_if.sv
// Branch-resolution update bus from execute into the fetch predictor.
// Unused by ifu_pc_gen unless IFU_BTB_EN is defined.
interface ifu_pc_gen_if;
  logic        bp_update;
  logic [31:0] bp_update_pc;
  logic [31:0] bp_update_target;
  logic        bp_update_taken;

  modport master (
    output bp_update,
    output bp_update_pc,
    output bp_update_target,
    output bp_update_taken
  );

  modport slave (
    input bp_update,
    input bp_update_pc,
    input bp_update_target,
    input bp_update_taken
  );
endinterface

// File: rtl/ifu_pc_gen_btb.sv
// Direct-mapped BTB: combinational lookup port, registered update port.
// Instantiated by ifu_pc_gen only when IFU_BTB_EN is defined.
module ifu_btb
  import ifu_pc_gen_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [InstAddrBus-1:0] lookup_pc_i,
  output logic                   hit_o,
  output logic                   taken_o,
  output logic [InstAddrBus-1:0] target_o,
  ifu_pc_gen_if.slave            upd_if
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = InstAddrBus - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  ctr_e               ctr_q [ENTRIES];

  logic [IDX-1:0] l_idx;
  logic [IDX-1:0] u_idx;
  logic [TW-1:0]  l_tag;
  logic [TW-1:0]  u_tag;
  logic           u_hit;
  logic [3:0]     unused_lo;

  assign l_idx = lookup_pc_i[IDX+1:2];
  assign l_tag = lookup_pc_i[31:IDX+2];
  assign u_idx = upd_if.bp_update_pc[IDX+1:2];
  assign u_tag = upd_if.bp_update_pc[31:IDX+2];

  assign unused_lo = {lookup_pc_i[1:0],
                      upd_if.bp_update_pc[1:0]};

  assign hit_o    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign taken_o  = hit_o && (ctr_q[l_idx] inside {CTR_WT, CTR_ST});
  assign target_o = tgt_q[l_idx];

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Only valid bits are reset; stale tags/targets are masked by valid
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      valid_q <= '0;
    end else if (upd_if.bp_update) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_step(ctr_q[u_idx], upd_if.bp_update_taken);
        if (upd_if.bp_update_taken) begin
          tgt_q[u_idx] <= upd_if.bp_update_target;
        end
      end else if (upd_if.bp_update_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_if.bp_update_target;
        ctr_q[u_idx]   <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/ifu_pc_gen.sv
// Fetch PC register, ROM enable and next-PC prediction.
// IFU_BTB_EN: build with the branch target buffer (default: sequential only).
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [5:0]             stall_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] flush_pc_i,
  input  logic                   branch_redirect_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  ifu_pc_gen_if.slave            bp_if,
  output logic [InstAddrBus-1:0] pc_o,
  output logic                   ce_o,
  output logic [InstAddrBus-1:0] next_pc_o,
  output logic                   next_branch_o,
  output logic                   branch_slot_end_o
);

  logic [InstAddrBus-1:0] pc_q;
  logic [InstAddrBus-1:0] pc_d;
  logic [InstAddrBus-1:0] pc_inc;
  logic                   ce_q;
  logic [4:0]             unused_stall;

  assign unused_stall = stall_i[5:1];
  assign pc_inc       = pc_q + 32'd4;

`ifdef IFU_BTB_EN
  logic                   btb_hit;
  logic                   btb_taken;
  logic [InstAddrBus-1:0] btb_target;

  ifu_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_pc_i (pc_q),
    .hit_o       (btb_hit),
    .taken_o     (btb_taken),
    .target_o    (btb_target),
    .upd_if      (bp_if)
  );

  assign next_branch_o     = btb_taken ? Branch : NotBranch;
  assign branch_slot_end_o = btb_hit;
  assign next_pc_o         = btb_taken ? btb_target : pc_inc;
`else
  logic [65:0] unused_bp;

  assign unused_bp = {bp_if.bp_update, bp_if.bp_update_pc,
                      bp_if.bp_update_target, bp_if.bp_update_taken};

  assign next_branch_o     = NotBranch;
  assign branch_slot_end_o = BranchNotEnd;
  assign next_pc_o         = pc_inc | ZeroWord;
`endif

  // Redirect beats flush; a stall only freezes the sequential path
  always_comb begin
    pc_d = next_pc_o;
    if (branch_redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (flush_i) begin
      pc_d = flush_pc_i;
    end else if (stall_i[0] == Stop) begin
      pc_d = pc_q;
    end else if (stall_i[0] == NoStop) begin
      pc_d = next_pc_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ce_q <= 1'b1;
    end
  end

  assign pc_o = pc_q;
  assign ce_o = ce_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Randomized self-checking bench for ifu_pc_gen against a behavioural model.
// Honours IFU_BTB_EN the same way as the design build.
module tb_ifu_pc_gen;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int NE  = 16;
  localparam int IDX = 4;
`ifdef IFU_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] next_pc_o;
  logic        next_branch_o;
  logic        bse_o;

  ifu_pc_gen_if bp_if ();

  ifu_pc_gen #(
    .RESET_PC    (RPC),
    .BTB_ENTRIES (NE)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .flush_pc_i        (flush_pc),
    .branch_redirect_i (redir),
    .redirect_pc_i     (redir_pc),
    .bp_if             (bp_if),
    .pc_o              (pc_o),
    .ce_o              (ce_o),
    .next_pc_o         (next_pc_o),
    .next_branch_o     (next_branch_o),
    .branch_slot_end_o (bse_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: PC, ce and a BTB kept as plain arrays
  logic [31:0] m_pc;
  bit          m_ce;
  bit          m_v   [NE];
  logic [31:0] m_tag [NE];
  logic [31:0] m_tgt [NE];
  int          m_ctr [NE];

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) % NE);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] a);
    return a >> (IDX + 2);
  endfunction

  function automatic bit m_hit();
    int i;
    i = idx_of(m_pc);
    return BTB_ON && m_v[i] && (m_tag[i] == tag_of(m_pc));
  endfunction

  function automatic bit m_taken();
    return m_hit() && (m_ctr[idx_of(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next();
    if (m_taken()) return m_tgt[idx_of(m_pc)];
    return m_pc + 32'd4;
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    int ui;
    bit uh;
    nxt = m_next();
    if (rst) begin
      m_pc = RPC;
      m_ce = 1'b0;
      for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
    end else begin
      if (BTB_ON && bp_if.bp_update) begin
        ui = idx_of(bp_if.bp_update_pc);
        uh = m_v[ui] && (m_tag[ui] == tag_of(bp_if.bp_update_pc));
        if (uh) begin
          if (bp_if.bp_update_taken) begin
            m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_tgt[ui] = bp_if.bp_update_target;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (bp_if.bp_update_taken) begin
          m_v[ui]   = 1'b1;
          m_tag[ui] = tag_of(bp_if.bp_update_pc);
          m_tgt[ui] = bp_if.bp_update_target;
          m_ctr[ui] = 2;
        end
      end
      if (redir)         m_pc = redir_pc;
      else if (flush)    m_pc = flush_pc;
      else if (stall[0]) m_pc = m_pc;
      else               m_pc = nxt;
      m_ce = 1'b1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc_o", pc_o, m_pc);
    chk("ce_o", {31'b0, ce_o}, {31'b0, m_ce});
    chk("next_pc_o", next_pc_o, m_next());
    chk("next_branch_o", {31'b0, next_branch_o}, {31'b0, m_taken()});
    chk("branch_slot_end_o", {31'b0, bse_o}, {31'b0, m_hit()});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst                    = 1'b0;
    stall                  = '0;
    flush                  = 1'b0;
    flush_pc               = '0;
    redir                  = 1'b0;
    redir_pc               = '0;
    bp_if.bp_update        = 1'b0;
    bp_if.bp_update_pc     = '0;
    bp_if.bp_update_target = '0;
    bp_if.bp_update_taken  = 1'b0;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 3) == 0) a = a | 32'h0000_1000;
    return a;
  endfunction

  logic [31:0] e_np;
  logic [31:0] e_br;

  initial begin
    idle();
    m_pc = '0;
    m_ce = 1'b0;
    for (int i = 0; i < NE; i++) begin
      m_v[i]   = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 0;
    end

    // Reset and sequential run
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_ce", {31'b0, ce_o}, 32'h0);
    chk("rst_next_pc", next_pc_o, 32'h104);
    chk("rst_nb", {31'b0, next_branch_o}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("seq_pc1", pc_o, 32'h104);
    chk("seq_ce", {31'b0, ce_o}, 32'h1);
    cyc();
    chk("seq_pc2", pc_o, 32'h108);

    // Redirect wins over flush
    redir = 1'b1; redir_pc = 32'h200;
    flush = 1'b1; flush_pc = 32'h80;
    cyc();
    chk("redir_pc", pc_o, 32'h200);
    idle();
    cyc();
    chk("redir_seq", pc_o, 32'h204);

    // Stall holds for three cycles
    redir = 1'b1; redir_pc = 32'h10;
    cyc();
    idle();
    stall = 6'b000001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_hold", pc_o, 32'h10);
    end
    idle();
    cyc();
    chk("stall_rel", pc_o, 32'h14);

    // Taken update allocates 0x20 -> 0x40
    redir = 1'b1; redir_pc = 32'h1C;
    bp_if.bp_update = 1'b1;
    bp_if.bp_update_pc = 32'h20;
    bp_if.bp_update_target = 32'h40;
    bp_if.bp_update_taken = 1'b1;
    cyc();
    chk("pre_hit_np", next_pc_o, 32'h20);
    idle();
    cyc();
`ifdef IFU_BTB_EN
    e_np = 32'h40; e_br = 32'h1;
`else
    e_np = 32'h24; e_br = 32'h0;
`endif
    chk("hit_pc", pc_o, 32'h20);
    chk("hit_np", next_pc_o, e_np);
    chk("hit_nb", {31'b0, next_branch_o}, e_br);
    chk("hit_bse", {31'b0, bse_o}, e_br);
    cyc();
    chk("hit_follow", pc_o, e_np);

    // Two not-taken updates drain the counter to 00
    redir = 1'b1; redir_pc = 32'h20;
    bp_if.bp_update = 1'b1;
    bp_if.bp_update_pc = 32'h20;
    bp_if.bp_update_taken = 1'b0;
    cyc();
    redir = 1'b0;
    stall = 6'b000001;
    cyc();
    idle();
    stall = 6'b000001;
    cyc();
    chk("nt_np", next_pc_o, 32'h24);
    chk("nt_nb", {31'b0, next_branch_o}, 32'h0);
    chk("nt_bse", {31'b0, bse_o}, e_br);

    // Wrap at top of address space
    idle();
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    cyc();
    chk("wrap_np", next_pc_o, 32'h0);
    idle();
    cyc();
    chk("wrap_pc", pc_o, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst                    = ($urandom_range(0, 199) == 0);
      stall                  = 6'($urandom);
      stall[0]               = ($urandom_range(0, 9) < 3);
      redir                  = ($urandom_range(0, 19) == 0);
      redir_pc               = rnd_pc();
      flush                  = ($urandom_range(0, 19) == 0);
      flush_pc               = rnd_pc();
      bp_if.bp_update        = ($urandom_range(0, 9) < 4);
      bp_if.bp_update_pc     = rnd_pc();
      bp_if.bp_update_target = rnd_pc();
      bp_if.bp_update_taken  = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
